// File: rtl/eth_pkg.sv
// eth_pkg: Ethernet framing constants and the GMII transmit state encoding
// shared by the transmit framer and its CRC helper.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  ETH_SFD_BYTE      = 8'hD5;
  localparam logic [31:0] ETH_CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC_INIT      = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_PREAMBLE,
    TX_SFD,
    TX_PAYLOAD,
    TX_PAD,
    TX_FCS,
    TX_DRAIN,
    TX_IFG
  } tx_state_t;

  // Byte counter increment that sticks at 2047 instead of wrapping.
  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: one byte of reflected CRC-32 (Ethernet polynomial), purely combinational.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  // Data bits enter LSB first, matching the on-wire bit order.
  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ (ETH_CRC_POLY & {32{c[0] ^ data_in[i]}});
    end
    crc_out = c;
  end

endmodule

// File: rtl/gmii_frame_tx.sv
// gmii_frame_tx: GMII transmit framer (preamble, SFD, payload, pad, IFG).
// Define GMII_TX_FCS_EN to compute and append the CRC-32 FCS in hardware.
module gmii_frame_tx
  import eth_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_PAYLOAD  = 60,
  parameter int IFG_CYCLES   = 12
) (
  input  logic       gmii_clk_in,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] gmii_data_out,
  output logic       gmii_valid_out,
  output logic       gmii_error_out,
  output logic       busy,
  output logic       frame_done,
  output logic       underflow
);

  tx_state_t   state_q, state_d;
  logic [15:0] cyc_q, cyc_d;
  logic [10:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0]  data_d;
  logic        valid_d, err_d, done_d, uf_d;

`ifdef GMII_TX_FCS_EN
  localparam bit        FCS_ON    = 1'b1;
  localparam tx_state_t BODY_EXIT = TX_FCS;

  logic [31:0] crc_q, crc_next;
  logic [7:0]  fcs_byte;
  logic        crc_en;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data_in (data_d),
    .crc_out (crc_next)
  );

  assign crc_en   = ((state_q == TX_PAYLOAD) && s_valid) || (state_q == TX_PAD);
  assign fcs_byte = 8'(~crc_q >> {cyc_q[1:0], 3'b000});

  always_ff @(posedge gmii_clk_in) begin
    if (!rst_n || state_q == TX_IDLE) crc_q <= ETH_CRC_INIT;
    else if (crc_en)                  crc_q <= crc_next;
  end
`else
  localparam bit        FCS_ON    = 1'b0;
  localparam tx_state_t BODY_EXIT = TX_IFG;
`endif

  assign cnt_inc = sat_inc11(cnt_q);
  assign busy    = (state_q != TX_IDLE);
  assign s_ready = (state_q == TX_PAYLOAD) || (state_q == TX_DRAIN);

  // Each state computes the byte for its own cycle; the registers below
  // present it one edge later, giving the one-cycle payload latency.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    cnt_d   = cnt_q;
    data_d  = 8'h00;
    valid_d = 1'b0;
    err_d   = 1'b0;
    done_d  = 1'b0;
    uf_d    = 1'b0;
    case (state_q)
      TX_IDLE: begin
        cyc_d = '0;
        cnt_d = '0;
        if (s_valid) state_d = TX_PREAMBLE;
      end
      TX_PREAMBLE: begin
        data_d  = ETH_PREAMBLE_BYTE;
        valid_d = 1'b1;
        if (cyc_q == 16'(PREAMBLE_LEN - 1)) begin
          cyc_d   = '0;
          state_d = TX_SFD;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      TX_SFD: begin
        data_d  = ETH_SFD_BYTE;
        valid_d = 1'b1;
        state_d = TX_PAYLOAD;
      end
      TX_PAYLOAD: begin
        valid_d = 1'b1;
        if (s_valid) begin
          data_d = s_data;
          cnt_d  = cnt_inc;
          if (s_last) begin
            if (cnt_inc < 11'(MIN_PAYLOAD)) begin
              state_d = TX_PAD;
            end else begin
              state_d = BODY_EXIT;
              done_d  = !FCS_ON;
            end
          end
        end else begin
          err_d   = 1'b1;
          uf_d    = 1'b1;
          state_d = TX_DRAIN;
        end
      end
      TX_PAD: begin
        valid_d = 1'b1;
        cnt_d   = cnt_inc;
        if (cnt_inc >= 11'(MIN_PAYLOAD)) begin
          state_d = BODY_EXIT;
          done_d  = !FCS_ON;
        end
      end
`ifdef GMII_TX_FCS_EN
      TX_FCS: begin
        data_d  = fcs_byte;
        valid_d = 1'b1;
        if (cyc_q[1:0] == 2'd3) begin
          cyc_d   = '0;
          done_d  = 1'b1;
          state_d = TX_IFG;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
`endif
      TX_DRAIN: begin
        if (s_valid && s_last) state_d = TX_IFG;
      end
      TX_IFG: begin
        if (cyc_q == 16'(IFG_CYCLES - 1)) begin
          cyc_d   = '0;
          state_d = TX_IDLE;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge gmii_clk_in) begin
    if (!rst_n) begin
      state_q        <= TX_IDLE;
      cyc_q          <= '0;
      cnt_q          <= '0;
      gmii_data_out  <= 8'h00;
      gmii_valid_out <= 1'b0;
      gmii_error_out <= 1'b0;
      frame_done     <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cyc_q          <= cyc_d;
      cnt_q          <= cnt_d;
      gmii_data_out  <= data_d;
      gmii_valid_out <= valid_d;
      gmii_error_out <= err_d;
      frame_done     <= done_d;
      underflow      <= uf_d;
    end
  end

endmodule
